// File: rtl/pulse_synth_pkg.sv
// Shared definitions for the synthetic pulse generator and related blocks.
package pulse_synth_pkg;

  localparam int unsigned VIDEO_SIZE_DEFAULT = 10;

  typedef enum logic [2:0] {
    StIdle = 3'b000,
    StRise = 3'b001,
    StHold = 3'b010,
    StFall = 3'b011,
    StGap  = 3'b100
  } state_e;

endpackage

// File: rtl/pulse_synth_sat_ramp.sv
// Saturating one-step ramp: adds (up) or subtracts (down) a step and clamps at a limit.
module sat_ramp #(
  parameter int unsigned WIDTH = 10
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic [WIDTH-1:0] i_step,
  input  logic [WIDTH-1:0] i_limit,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_value
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_floor;

  // One extra bit so neither direction can wrap before the clamp.
  always_comb begin
    w_sum   = {1'b0, i_value} + {1'b0, i_step};
    w_floor = {1'b0, i_limit} + {1'b0, i_step};
    o_value = i_value;
    if (i_up) begin
      if ((i_step == '0) || (w_sum >= {1'b0, i_limit})) begin
        o_value = i_limit;
      end else begin
        o_value = w_sum[WIDTH-1:0];
      end
    end else begin
      if ((i_step == '0) || ({1'b0, i_value} <= w_floor)) begin
        o_value = i_limit;
      end else begin
        o_value = i_value - i_step;
      end
    end
  end

endmodule

// File: rtl/pulse_synth.sv
// Synthetic video pulse-train generator: trapezoidal pulses repeated at a
// programmable interval, with optional train length and stop request.
module pulse_synth
  import pulse_synth_pkg::*;
#(
  parameter int unsigned VIDEO_SIZE = VIDEO_SIZE_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  stop,
  input  logic [31:0]           pw,
  input  logic [VIDEO_SIZE-1:0] pa,
  input  logic [31:0]           pri,
  input  logic [VIDEO_SIZE-1:0] step,
  input  logic [15:0]           num_pulses,
  output logic [VIDEO_SIZE-1:0] video,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           PC
);

  state_e                r_state;
  logic [VIDEO_SIZE-1:0] r_video;
  logic                  r_busy;
  logic                  r_done;
  logic [31:0]           r_pc;
  logic [31:0]           r_pw;
  logic [VIDEO_SIZE-1:0] r_pa;
  logic [31:0]           r_pri;
  logic [VIDEO_SIZE-1:0] r_step;
  logic [15:0]           r_num;
  logic                  r_stop;
  logic [31:0]           r_hold_cnt;
  logic [31:0]           r_per_cnt;

  logic [VIDEO_SIZE-1:0] w_ramp;
  logic [VIDEO_SIZE-1:0] w_limit;
  logic                  w_up;
  logic                  w_hold_over;
  logic                  w_stop_seen;
  logic                  w_train_done;
  logic                  w_pulse_end;
  logic                  w_finish;
  logic [31:0]           w_per_inc;
  state_e                w_after_fall;

  assign w_up    = (r_state == StRise);
  assign w_limit = w_up ? r_pa : '0;

  sat_ramp #(
    .WIDTH (VIDEO_SIZE)
  ) u_ramp (
    .i_value (r_video),
    .i_step  (r_step),
    .i_limit (w_limit),
    .i_up    (w_up),
    .o_value (w_ramp)
  );

  assign w_hold_over  = (r_hold_cnt >= r_pw);
  assign w_stop_seen  = r_stop | stop;
  assign w_train_done = ((r_num != 16'd0) && (r_pc == {16'd0, r_num})) || w_stop_seen;
  assign w_pulse_end  = (((r_state == StHold) && w_hold_over) || (r_state == StFall)) &&
                        (w_ramp == '0);
  assign w_finish     = (w_pulse_end && w_train_done) || ((r_state == StGap) && w_stop_seen);
  assign w_per_inc    = (r_per_cnt == '1) ? r_per_cnt : r_per_cnt + 32'd1;
  assign w_after_fall = (w_ramp != '0) ? StFall : (w_train_done ? StIdle : StGap);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_video    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pc       <= '0;
      r_pw       <= '0;
      r_pa       <= '0;
      r_pri      <= '0;
      r_step     <= '0;
      r_num      <= '0;
      r_stop     <= 1'b0;
      r_hold_cnt <= '0;
      r_per_cnt  <= '0;
    end else if (enable) begin
      r_done <= 1'b0;
      if (r_state != StIdle) begin
        r_per_cnt <= w_per_inc;
        if (stop) r_stop <= 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_pw      <= (pw == 32'd0) ? 32'd1 : pw;
            r_pa      <= pa;
            r_pri     <= pri;
            r_step    <= step;
            r_num     <= num_pulses;
            r_pc      <= '0;
            r_busy    <= 1'b1;
            r_stop    <= 1'b0;
            r_per_cnt <= '0;
            r_video   <= '0;
            r_state   <= StRise;
          end
        end
        StRise: begin
          r_video <= w_ramp;
          if (w_ramp == r_pa) begin
            r_state    <= StHold;
            r_hold_cnt <= 32'd1;
            if (r_pc != '1) r_pc <= r_pc + 32'd1;
          end
        end
        StHold: begin
          // The last hold cycle already applies the first fall step.
          if (w_hold_over) begin
            r_video <= w_ramp;
            r_state <= w_after_fall;
          end else begin
            r_hold_cnt <= r_hold_cnt + 32'd1;
          end
        end
        StFall: begin
          r_video <= w_ramp;
          r_state <= w_after_fall;
        end
        StGap: begin
          if (w_stop_seen) begin
            r_state <= StIdle;
          end else if (w_per_inc >= r_pri) begin
            r_state   <= StRise;
            r_per_cnt <= '0;
          end
        end
        default: r_state <= StIdle;
      endcase
      if (w_finish) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign video = r_video;
  assign busy  = r_busy;
  assign done  = r_done;
  assign PC    = r_pc;

endmodule
